// File: rtl/div_seq_ctrl.sv
// Radix-2 shift-subtract divide sequencer for DIV/DIVU with HI/LO results.
// Optional macro DIV_EARLY_OUT_EN: skip the iteration loop when |dividend| < |divisor|.
module div_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             annul,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             stall_o,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ZERO = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dsr;
    logic [WIDTH-1:0] r_result_hi;
    logic [WIDTH-1:0] r_result_lo;
    logic             r_qneg;
    logic             r_rneg;
    logic             r_early;

    logic             w_accept;
    logic             w_last;
    logic             w_ge;
    logic             w_early;
    logic             w_div0;
    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_shift_rem;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_dvd_nxt;

    function automatic logic [WIDTH-1:0] f_neg_if(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    assign w_sa     = signed_div & opa[WIDTH-1];
    assign w_sb     = signed_div & opb[WIDTH-1];
    assign w_abs_a  = f_neg_if(w_sa, opa);
    assign w_abs_b  = f_neg_if(w_sb, opb);
    assign w_div0   = (opb == {WIDTH{1'b0}});
    assign w_accept = (r_state == S_IDLE) & start & ~annul;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef DIV_EARLY_OUT_EN
    assign w_early = ~w_div0 & (w_abs_a < w_abs_b);
`else
    assign w_early = 1'b0;
`endif

    // The remainder after a subtract is always below the divisor, so WIDTH bits hold it.
    assign w_shift_rem = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge        = (w_shift_rem >= {1'b0, r_dsr});
    assign w_diff      = w_shift_rem[WIDTH-1:0] - r_dsr;
    assign w_rem_nxt   = w_ge ? w_diff : w_shift_rem[WIDTH-1:0];
    assign w_dvd_nxt   = {r_dvd[WIDTH-2:0], w_ge};

    assign stall_o   = ~annul & (((r_state == S_IDLE) & start) | (r_state == S_BUSY) | (r_state == S_ZERO));
    assign done      = (r_state == S_DONE) & ~annul;
    assign result_hi = r_result_hi;
    assign result_lo = r_result_lo;

    // Next-state selection
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_div0 | w_early) begin
                        w_state_nxt = S_ZERO;
                    end else begin
                        w_state_nxt = S_BUSY;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY: begin
                if (annul) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_ZERO: begin
                if (annul) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register, iteration datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= {CNT_W{1'b0}};
            r_rem       <= {WIDTH{1'b0}};
            r_dvd       <= {WIDTH{1'b0}};
            r_dsr       <= {WIDTH{1'b0}};
            r_result_hi <= {WIDTH{1'b0}};
            r_result_lo <= {WIDTH{1'b0}};
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            r_early     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= {CNT_W{1'b0}};
                        r_rem   <= {WIDTH{1'b0}};
                        // Divide-by-zero returns the dividend untouched in HI.
                        r_dvd   <= w_div0 ? opa : w_abs_a;
                        r_dsr   <= w_abs_b;
                        r_qneg  <= w_sa ^ w_sb;
                        r_rneg  <= w_sa;
                        r_early <= w_early;
                    end
                end
                S_BUSY: begin
                    if (!annul) begin
                        r_rem <= w_rem_nxt;
                        r_dvd <= w_dvd_nxt;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_result_lo <= f_neg_if(r_qneg, w_dvd_nxt);
                            r_result_hi <= f_neg_if(r_rneg, w_rem_nxt);
                        end
                    end
                end
                S_ZERO: begin
                    if (!annul) begin
                        r_result_lo <= r_early ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
                        r_result_hi <= r_early ? f_neg_if(r_rneg, r_dvd) : r_dvd;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: expected HI/LO queued at issue, compared on done.
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] opa = 32'd0;
    logic [31:0] opb = 32'd0;
    logic        stall_o;
    logic        done;
    logic [31:0] result_hi;
    logic [31:0] result_lo;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] act_q[$];
    logic [63:0] last_res = 64'd0;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    div_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .annul(annul),
        .opa(opa), .opb(opb), .stall_o(stall_o), .done(done),
        .result_hi(result_hi), .result_lo(result_lo)
    );

    always #5 clk = ~clk;

    // Capture every done pulse as an observed {hi, lo}
    always @(negedge clk) begin
        if (!rst && done === 1'b1) act_q.push_back({result_hi, result_lo});
    end

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] ua, ub, q, r;
        logic sa, sb;
        sa = s & a[31];
        sb = s & b[31];
        ua = sa ? (32'd0 - a) : a;
        ub = sb ? (32'd0 - b) : b;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = ua / ub;
        r = ua % ub;
        if (sa ^ sb) q = 32'd0 - q;
        if (sa) r = 32'd0 - r;
        return {r, q};
    endfunction

    function automatic int model_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] ua, ub;
        ua = (s & a[31]) ? (32'd0 - a) : a;
        ub = (s & b[31]) ? (32'd0 - b) : b;
        if (b == 32'd0) return 2;
        if (EARLY_EN && ua < ub) return 2;
        return 33;
    endfunction

    // Issue one op in the next cycle, hold start until done, report latency and stall errors
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int lat, output int stall_err);
        @(posedge clk); #1;
        start = 1'b1; signed_div = s; opa = a; opb = b;
        lat = -1; stall_err = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = c;
                if (stall_o !== 1'b0) stall_err++;
                break;
            end
            if (stall_o !== 1'b1) stall_err++;
        end
        start = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall_o); end
        n_checks++; if ({result_hi, result_lo} !== 64'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", {result_hi, result_lo}); end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({done, stall_o} !== 2'b00) begin n_fail++; $display("FAIL post_reset_idle got %b want 00", {done, stall_o}); end
    endtask

    task automatic test_divide_table;
        logic [31:0] ta[7] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'hFFFF_FFFD, 32'd3, 32'hFFFF_FFFD};
        logic [31:0] tb[7] = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd10, 32'd10};
        logic        ts[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [63:0] te[7] = '{{32'd2, 32'd14}, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'd0, 32'h8000_0000},
                               {32'd5, 32'hFFFF_FFFF}, {32'hFFFF_FFFD, 32'hFFFF_FFFF},
                               {32'd3, 32'd0}, {32'hFFFF_FFFD, 32'd0}};
        int tl[7];
        int lat, serr;
        logic [63:0] e, g;
        tl = '{33, 33, 33, 2, 2, EARLY_EN ? 2 : 33, EARLY_EN ? 2 : 33};
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(te[i]);
            run_op(ta[i], tb[i], ts[i], lat, serr);
            n_checks++; if (lat !== tl[i]) begin n_fail++; $display("FAIL div%0d_latency got %0d want %0d", i, lat, tl[i]); end
            n_checks++; if (serr !== 0) begin n_fail++; $display("FAIL div%0d_stall got %0d bad cycles want 0", i, serr); end
            e = exp_q.pop_front();
            n_checks++;
            if (act_q.size() == 0) begin
                n_fail++; $display("FAIL div%0d_result got none want %h", i, e);
            end else begin
                g = act_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL div%0d_result got %h want %h", i, g, e); end
            end
            last_res = e;
        end
    endtask

    task automatic test_back_to_back;
        int lat1, lat2, s1, s2;
        logic [63:0] e, g;
        exp_q.push_back({32'd1, 32'd2});
        exp_q.push_back({32'd1, 32'hFFFF_FFFE});
        run_op(32'd9, 32'd4, 1'b0, lat1, s1);
        run_op(32'd9, 32'hFFFF_FFFC, 1'b1, lat2, s2);
        n_checks++; if (lat1 !== 33 || lat2 !== 33) begin n_fail++; $display("FAIL b2b_latency got %0d,%0d want 33,33", lat1, lat2); end
        n_checks++; if (s1 + s2 !== 0) begin n_fail++; $display("FAIL b2b_stall got %0d bad cycles want 0", s1 + s2); end
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (act_q.size() == 0) begin
                n_fail++; $display("FAIL b2b%0d_result got none want %h", i, e);
            end else begin
                g = act_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL b2b%0d_result got %h want %h", i, g, e); end
            end
            last_res = e;
        end
    endtask

    task automatic test_annul;
        bit saw_done;
        // annul in IDLE must block the accept
        @(posedge clk); #1; start = 1'b1; annul = 1'b1; signed_div = 1'b0; opa = 32'd1000; opb = 32'd3;
        @(negedge clk);
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL annul_idle_stall got %b want 0", stall_o); end
        @(posedge clk); #1; start = 1'b0; annul = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if ({stall_o, done} !== 2'b00) begin n_fail++; $display("FAIL annul_idle_noaccept got %b want 00", {stall_o, done}); end
        // annul mid-BUSY at cycle 10
        @(posedge clk); #1; start = 1'b1; opa = 32'd1000; opb = 32'd3;
        repeat (10) @(posedge clk);
        #1; annul = 1'b1; start = 1'b0;
        @(negedge clk);
        n_checks++; if ({stall_o, done} !== 2'b00) begin n_fail++; $display("FAIL annul_cycle10 got %b want 00", {stall_o, done}); end
        @(posedge clk); #1; annul = 1'b0;
        @(negedge clk);
        n_checks++; if ({stall_o, done} !== 2'b00) begin n_fail++; $display("FAIL annul_cycle11_idle got %b want 00", {stall_o, done}); end
        n_checks++; if ({result_hi, result_lo} !== last_res) begin n_fail++; $display("FAIL annul_keep_result got %h want %h", {result_hi, result_lo}, last_res); end
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || stall_o === 1'b1) saw_done = 1'b1;
        end
        n_checks++; if (saw_done || act_q.size() != 0) begin n_fail++; $display("FAIL annul_no_done got activity want none"); end
        // reset asserted mid-BUSY of a new op
        @(posedge clk); #1; start = 1'b1; opa = 32'd1000; opb = 32'd3;
        repeat (5) @(posedge clk);
        #2; rst = 1'b1; start = 1'b0;
        #1;
        n_checks++; if ({done, stall_o, result_hi, result_lo} !== 66'd0) begin
            n_fail++; $display("FAIL rst_mid_busy got %b %b %h want all 0", done, stall_o, {result_hi, result_lo});
        end
        @(posedge clk); #1; rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if ({done, stall_o, result_hi, result_lo} !== 66'd0) begin
            n_fail++; $display("FAIL rst_release_idle got %b %b %h want all 0", done, stall_o, {result_hi, result_lo});
        end
        last_res = 64'd0;
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        logic s;
        int lat, serr, el;
        logic [63:0] e, g;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i % 3 == 0) ? ($urandom & 32'h0000_00FF) : $urandom;
            if (i == 5) b = 32'd0;
            s = i[0];
            el = model_lat(a, b, s);
            exp_q.push_back(model(a, b, s));
            run_op(a, b, s, lat, serr);
            n_checks++; if (lat !== el || serr !== 0) begin n_fail++; $display("FAIL rnd%0d_timing got lat %0d stallerr %0d want %0d 0", i, lat, serr, el); end
            e = exp_q.pop_front();
            n_checks++;
            if (act_q.size() == 0) begin
                n_fail++; $display("FAIL rnd%0d_result got none want %h", i, e);
            end else begin
                g = act_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL rnd%0d_result a=%h b=%h s=%b got %h want %h", i, a, b, s, g, e); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_divide_table();
        test_back_to_back();
        test_annul();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
